// File: rtl/sram_rr_arbiter_if.sv
// Bundle of request, read-return and SRAM-controller signals for sram_rr_arbiter.
//   master : the arbiter's view (drives grants, command, read returns, status)
//   slave  : the environment's view (requesters, return FIFOs, SRAM controller)
// Multi-port buses are packed; port p occupies slice [p*W +: W].
interface sram_rr_arbiter_if #(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned ADDR_W          = 18,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MASK_W          = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        req_write;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_data;
  logic [NUM_PORTS*MASK_W-1:0] req_mask;
  logic [NUM_PORTS-1:0]        rd_space;
  logic [NUM_PORTS-1:0]        rd_valid;
  logic [DATA_W-1:0]           rd_data;
  logic                        sram_addr_valid;
  logic                        sram_ready;
  logic [ADDR_W-1:0]           sram_addr;
  logic [DATA_W-1:0]           sram_data_in;
  logic [MASK_W-1:0]           sram_write_mask;
  logic [DATA_W-1:0]           sram_data_out;
  logic                        sram_data_out_valid;
  logic [CNT_W-1:0]            outstanding;
  logic                        err_unexpected;

  modport master (
    input  req_valid, req_write, req_addr, req_data, req_mask, rd_space,
           sram_ready, sram_data_out, sram_data_out_valid,
    output req_ready, rd_valid, rd_data, sram_addr_valid, sram_addr,
           sram_data_in, sram_write_mask, outstanding, err_unexpected
  );

  modport slave (
    output req_valid, req_write, req_addr, req_data, req_mask, rd_space,
           sram_ready, sram_data_out, sram_data_out_valid,
    input  req_ready, rd_valid, rd_data, sram_addr_valid, sram_addr,
           sram_data_in, sram_write_mask, outstanding, err_unexpected
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// N-port round-robin (or fixed-priority) arbiter in front of the SRAM controller.
// Ports:
//   sram_clock : sole clock, rising edge
//   reset_n    : asynchronous active-low reset
//   bus        : sram_rr_arbiter_if.master -- per-port requests, one-hot combinational
//                grant (req_ready), registered SRAM command, registered read return
//                routed by an in-order tag queue, outstanding-read count, sticky error.
module sram_rr_arbiter #(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned ADDR_W          = 18,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MASK_W          = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned FIXED_PRIORITY  = 0
) (
  input  logic              sram_clock,
  input  logic              reset_n,
  sram_rr_arbiter_if.master bus
);
  localparam int unsigned TAG_W = $clog2(NUM_PORTS);
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [MASK_W-1:0]    mask_q, mask_d;
  logic [NUM_PORTS-1:0] rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic [TAG_W-1:0]     last_q, last_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_q, err_d;
  logic [TAG_W-1:0]     tag_mem [MAX_OUTSTANDING];

  logic                 tq_full_c, tq_empty_c, slot_free_c;
  logic [NUM_PORTS-1:0] elig_c, grant_c;
  logic                 gnt_vld_c;
  logic [TAG_W-1:0]     gnt_idx_c;
  logic                 push_c, pop_c;

  assign tq_full_c   = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign tq_empty_c  = (count_q == '0);
  // Reset gates the slot so req_ready drops the moment reset_n falls.
  assign slot_free_c = reset_n & ((state_q == IDLE) | bus.sram_ready);

  // Eligibility and rotating search starting after the last granted port.
  always_comb begin
    int unsigned start;
    int unsigned idx;
    elig_c    = '0;
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      elig_c[p] = bus.req_valid[p] & (bus.req_write[p] | (bus.rd_space[p] & ~tq_full_c));
    end
    start = (FIXED_PRIORITY != 0) ? 32'd0 : ((32'(last_q) + 32'd1) % NUM_PORTS);
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      idx = (start + 32'(i)) % NUM_PORTS;
      if (!gnt_vld_c && elig_c[idx]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = TAG_W'(idx);
      end
    end
    gnt_vld_c = gnt_vld_c & slot_free_c;
    grant_c   = gnt_vld_c ? (NUM_PORTS'(1) << gnt_idx_c) : '0;
  end

  assign push_c = gnt_vld_c & ~bus.req_write[gnt_idx_c];
  // Returns with nothing in flight are dropped and flagged instead of popped.
  assign pop_c  = bus.sram_data_out_valid & ~tq_empty_c;

  // Next-state: FSM, command register, tag-queue pointers, read return.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    last_d     = last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    err_d      = err_q | (bus.sram_data_out_valid & tq_empty_c);

    case (state_q)
      IDLE:    if (gnt_vld_c) state_d = ISSUE;
      ISSUE:   if (bus.sram_ready && !gnt_vld_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (gnt_vld_c) begin
      addr_d = bus.req_addr[32'(gnt_idx_c)*ADDR_W +: ADDR_W];
      data_d = bus.req_data[32'(gnt_idx_c)*DATA_W +: DATA_W];
      mask_d = bus.req_write[gnt_idx_c] ? bus.req_mask[32'(gnt_idx_c)*MASK_W +: MASK_W] : '0;
      last_d = gnt_idx_c;
    end

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      rd_valid_d = NUM_PORTS'(1) << tag_mem[rd_ptr_q];
      rd_data_d  = bus.sram_data_out;
    end
    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      last_q     <= TAG_W'(NUM_PORTS - 1);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

  // Tag storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge sram_clock) begin
    if (push_c) tag_mem[wr_ptr_q] <= gnt_idx_c;
  end

  assign bus.req_ready       = grant_c;
  assign bus.sram_addr_valid = state_q;
  assign bus.sram_addr       = addr_q;
  assign bus.sram_data_in    = data_q;
  assign bus.sram_write_mask = mask_q;
  assign bus.rd_valid        = rd_valid_q;
  assign bus.rd_data         = rd_data_q;
  assign bus.outstanding     = count_q;
  assign bus.err_unexpected  = err_q;
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter: round-robin and fixed-priority instances share
// stimulus; accepted SRAM commands and read returns are checked against queues.
module tb_sram_rr_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned MO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_rr_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .MAX_OUTSTANDING(MO)) bus ();
  sram_rr_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .MAX_OUTSTANDING(MO)) bus_fp ();

  sram_rr_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
                    .MAX_OUTSTANDING(MO), .FIXED_PRIORITY(0))
    dut (.sram_clock(clk), .reset_n(rst_n), .bus(bus));

  sram_rr_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
                    .MAX_OUTSTANDING(MO), .FIXED_PRIORITY(1))
    dut_fp (.sram_clock(clk), .reset_n(rst_n), .bus(bus_fp));

  assign bus_fp.req_valid           = bus.req_valid;
  assign bus_fp.req_write           = bus.req_write;
  assign bus_fp.req_addr            = bus.req_addr;
  assign bus_fp.req_data            = bus.req_data;
  assign bus_fp.req_mask            = bus.req_mask;
  assign bus_fp.rd_space            = bus.rd_space;
  assign bus_fp.sram_ready          = bus.sram_ready;
  assign bus_fp.sram_data_out       = bus.sram_data_out;
  assign bus_fp.sram_data_out_valid = bus.sram_data_out_valid;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } cmd_t;
  typedef struct {
    logic [N-1:0]  vld;
    logic [DW-1:0] data;
  } ret_t;

  cmd_t          cmd_q[$];
  ret_t          rd_q[$];
  int            vectors     = 0;
  int            miscompares = 0;
  bit            chk_fp      = 1'b0;
  logic [N-1:0]  exp_fp      = '0;
  logic [DW-1:0] last_rd     = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic v, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [MW-1:0] m);
    bus.req_valid[p]          = v;
    bus.req_write[p]          = w;
    bus.req_addr[p*AW +: AW]  = a;
    bus.req_data[p*DW +: DW]  = d;
    bus.req_mask[p*MW +: MW]  = m;
  endtask

  // One cycle: check the grant, score an accepted command, push the newly granted
  // port's expected command, cross the edge and score any read return.
  task automatic step(input logic [N-1:0] exp);
    cmd_t c;
    cmd_t e;
    ret_t r;
    logic ret;
    int   gp;
    #1;
    check("req_ready", 64'(bus.req_ready), 64'(exp));
    if (chk_fp) check("fp_req_ready", 64'(bus_fp.req_ready), 64'(exp_fp));
    if (bus.sram_addr_valid && bus.sram_ready) begin
      if (cmd_q.size() == 0) check("cmd_queue_depth", 64'(cmd_q.size()), 64'(1));
      else begin
        e = cmd_q.pop_front();
        check("sram_addr", 64'(bus.sram_addr), 64'(e.addr));
        check("sram_data_in", 64'(bus.sram_data_in), 64'(e.data));
        check("sram_write_mask", 64'(bus.sram_write_mask), 64'(e.mask));
      end
    end
    gp = -1;
    for (int i = 0; i < int'(N); i++) if (exp[i]) gp = i;
    if (gp >= 0) begin
      c.addr = bus.req_addr[gp*AW +: AW];
      c.data = bus.req_data[gp*DW +: DW];
      c.mask = bus.req_write[gp] ? bus.req_mask[gp*MW +: MW] : '0;
      cmd_q.push_back(c);
    end
    ret = bus.sram_data_out_valid;
    @(posedge clk);
    #1;
    if (ret) begin
      if (rd_q.size() == 0) check("ret_queue_depth", 64'(rd_q.size()), 64'(1));
      else begin
        r = rd_q.pop_front();
        check("rd_valid", 64'(bus.rd_valid), 64'(r.vld));
        check("rd_data", 64'(bus.rd_data), 64'(r.data));
      end
    end
  endtask

  // Present one read return from the controller for a cycle.
  task automatic ret_step(input logic [N-1:0] exp_gnt, input logic [DW-1:0] d,
                          input logic [N-1:0] exp_vld);
    ret_t r;
    bus.sram_data_out       = d;
    bus.sram_data_out_valid = 1'b1;
    r.vld  = exp_vld;
    r.data = (exp_vld != '0) ? d : last_rd;
    if (exp_vld != '0) last_rd = d;
    rd_q.push_back(r);
    step(exp_gnt);
    bus.sram_data_out_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    check({tag, "_addr_valid"}, 64'(bus.sram_addr_valid), 64'(0));
    check({tag, "_sram_addr"}, 64'(bus.sram_addr), 64'(0));
    check({tag, "_data_in"}, 64'(bus.sram_data_in), 64'(0));
    check({tag, "_wmask"}, 64'(bus.sram_write_mask), 64'(0));
    check({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'(0));
    check({tag, "_rd_data"}, 64'(bus.rd_data), 64'(0));
    check({tag, "_outstanding"}, 64'(bus.outstanding), 64'(0));
    check({tag, "_err"}, 64'(bus.err_unexpected), 64'(0));
  endtask

  initial begin
    rst_n                   = 1'b0;
    bus.req_valid           = '0;
    bus.req_write           = '0;
    bus.req_addr            = '0;
    bus.req_data            = '0;
    bus.req_mask            = '0;
    bus.rd_space            = '0;
    bus.sram_ready          = 1'b0;
    bus.sram_data_out       = '0;
    bus.sram_data_out_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All ports write: RR rotates 0,1,2,3,0,1; fixed priority always picks port 0.
    for (int p = 0; p < int'(N); p++)
      set_port(p, 1'b1, 1'b1, AW'(18'h100 + p), 32'hA000_0000 + 32'(p), MW'(p + 1));
    bus.sram_ready = 1'b1;
    bus.rd_space   = '1;
    chk_fp = 1'b1;
    exp_fp = 4'b0001;
    for (int k = 0; k < 6; k++) step(4'(1) << (k % 4));
    bus.req_valid[0] = 1'b0;
    exp_fp = 4'b0010;
    step(4'b0100);
    chk_fp = 1'b0;
    bus.req_valid = '0;
    step(4'b0000);
    check("idle_after_burst", 64'(bus.sram_addr_valid), 64'(0));

    // Port 2 read held through a 3-cycle stall, then returned.
    set_port(2, 1'b1, 1'b0, 18'h00010, 32'h2222_2222, 4'hF);
    bus.sram_ready = 1'b0;
    step(4'b0100);
    bus.req_valid = '0;
    for (int j = 0; j < 3; j++) begin
      check("stall_valid", 64'(bus.sram_addr_valid), 64'(1));
      check("stall_addr", 64'(bus.sram_addr), 64'(18'h00010));
      check("stall_mask", 64'(bus.sram_write_mask), 64'(0));
      step(4'b0000);
    end
    bus.sram_ready = 1'b1;
    check("outstanding_one", 64'(bus.outstanding), 64'(1));
    step(4'b0000);
    ret_step(4'b0000, 32'hDEAD_BEEF, 4'b0100);
    step(4'b0000);
    check("rd_valid_strobe", 64'(bus.rd_valid), 64'(0));
    check("outstanding_zero", 64'(bus.outstanding), 64'(0));

    // Fill the tag queue; a full queue blocks reads but not writes.
    set_port(0, 1'b1, 1'b0, 18'h00200, 32'h0000_0000, 4'h0);
    for (int k = 0; k < int'(MO); k++) step(4'b0001);
    check("outstanding_full", 64'(bus.outstanding), 64'(MO));
    bus.req_valid[0] = 1'b0;
    set_port(1, 1'b1, 1'b0, 18'h00301, 32'h1111_1111, 4'h0);
    set_port(3, 1'b1, 1'b1, 18'h00303, 32'h3333_3333, 4'hC);
    step(4'b1000);
    bus.req_valid[3] = 1'b0;
    step(4'b0000);
    ret_step(4'b0000, 32'h1111_0000, 4'b0001);
    check("outstanding_after_pop", 64'(bus.outstanding), 64'(MO - 1));
    ret_step(4'b0010, 32'h1111_0001, 4'b0001);
    bus.req_valid = '0;
    check("outstanding_grant_and_pop", 64'(bus.outstanding), 64'(MO - 1));
    for (int k = 0; k < 7; k++) ret_step(4'b0000, 32'hC0DE_0000 + 32'(k), (k < 6) ? 4'b0001 : 4'b0010);
    check("outstanding_drained", 64'(bus.outstanding), 64'(0));

    // rd_space low holds back port 0's read while port 1's write proceeds.
    bus.rd_space = 4'b1110;
    set_port(0, 1'b1, 1'b0, 18'h000AA, 32'h0000_0000, 4'h0);
    set_port(1, 1'b1, 1'b1, 18'h000BB, 32'hBBBB_BBBB, 4'h3);
    step(4'b0010);
    bus.req_valid[1] = 1'b0;
    step(4'b0000);
    bus.rd_space = '1;
    step(4'b0001);
    bus.req_valid = '0;
    ret_step(4'b0000, 32'h5A5A_5A5A, 4'b0001);
    step(4'b0000);

    // Return with nothing in flight: dropped and flagged until reset.
    check("outstanding_before_err", 64'(bus.outstanding), 64'(0));
    ret_step(4'b0000, 32'h1234_5678, 4'b0000);
    check("err_set", 64'(bus.err_unexpected), 64'(1));
    step(4'b0000);
    step(4'b0000);
    check("err_sticky", 64'(bus.err_unexpected), 64'(1));

    // Reset mid-burst with a read in flight.
    for (int p = 0; p < int'(N); p++)
      set_port(p, 1'b1, (p != 2), AW'(18'h400 + p), 32'hE000_0000 + 32'(p), 4'hF);
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    check("outstanding_pre_reset", 64'(bus.outstanding), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    cmd_q.delete();
    rd_q.delete();
    bus.req_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_err", 64'(bus.err_unexpected), 64'(0));
    check("post_reset_outstanding", 64'(bus.outstanding), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_rr_arbiter.md
# sram_rr_arbiter

Parametrised, single-clock, N-port round-robin arbiter between sram_clock-domain request FIFOs and the SRAM controller. Each port may issue reads or writes. Read data returning from the controller is routed back to the originating port through an in-order tag queue. Clock-domain crossing FIFOs sit outside this block; this block replaces the fixed two-writer/two-reader arbiter.

## Interface
- NUM_PORTS, 4: number of requester ports (2..8)
- ADDR_W, 18: SRAM word address width
- DATA_W, 32: data width
- MASK_W, 4: byte write-mask width (DATA_W/8)
- MAX_OUTSTANDING, 8: tag-queue depth, i.e. the maximum number of reads in flight (power of two)
- FIXED_PRIORITY, 0: 0 = round-robin; 1 = fixed priority, lowest index wins

- sram_clock  in  1  sole clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_PORTS  per-port request present
- req_ready  out  NUM_PORTS  one-hot grant; the request is consumed this cycle
- req_write  in  NUM_PORTS  1 = write, 0 = read
- req_addr  in  NUM_PORTS*ADDR_W  packed; port p occupies [p*ADDR_W +: ADDR_W]
- req_data  in  NUM_PORTS*DATA_W  packed write data
- req_mask  in  NUM_PORTS*MASK_W  packed write byte mask; must be nonzero for writes
- rd_space  in  NUM_PORTS  port p's return FIFO can take one more word
- rd_valid  out  NUM_PORTS  one-hot, one-cycle strobe for returned read data
- rd_data  out  DATA_W  returned read data, shared by all ports
- sram_addr_valid  out  1  command valid to the controller
- sram_ready  in  1  controller accepts the command
- sram_addr  out  ADDR_W  command address
- sram_data_in  out  DATA_W  write data
- sram_write_mask  out  MASK_W  write mask; all zeros for a read
- sram_data_out  in  DATA_W  read data from the controller
- sram_data_out_valid  in  1  read data valid; returns are in issue order
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  number of reads in flight
- err_unexpected  out  1  sticky flag: data returned with the tag queue empty

## Operation
- Port p is eligible when req_valid[p] is high and either:
  - the request is a write; or
  - the request is a read, rd_space[p] is high, and the tag queue is not full.
- The command slot is free when sram_addr_valid is 0, or when sram_addr_valid and sram_ready are both high.
- Grant happens only when the slot is free and at least one port is eligible. Exactly one req_ready bit is asserted, combinationally, in that cycle.
- Round-robin mode:
  - Search starts at last_grant+1 mod NUM_PORTS and takes the first eligible port.
  - last_grant updates only on a grant.
  - Reset value of last_grant is NUM_PORTS-1, so port 0 is searched first.
- Fixed-priority mode: the lowest eligible index wins; last_grant is ignored.
- On grant, the command register loads the port's addr and data, plus its mask for a write or all zeros for a read. sram_addr_valid = 1 on the next cycle.
- A read grant also pushes the port index onto the tag queue and increments outstanding.
- Commands are held stable while sram_addr_valid=1 and sram_ready=0.
- Read return:
  - On sram_data_out_valid, pop the tag queue. Register rd_data = sram_data_out and rd_valid[tag] = 1 for one cycle.
  - outstanding decrements on each pop.
- A read grant and a return in the same cycle leave outstanding unchanged.
- Tag queue full: reads are ineligible even if a pop occurs in the same cycle; writes still proceed.
- sram_data_out_valid with the tag queue empty: no rd_valid, no pop, err_unexpected set until reset.
- States: IDLE (sram_addr_valid=0) and ISSUE (sram_addr_valid=1).
  - IDLE to ISSUE on a grant.
  - ISSUE stays in ISSUE on stall, or on accept plus a new grant.
  - ISSUE to IDLE on accept with no grant.
- Reset:
  - Asserting reset_n low at any time clears the command register, tag queue, outstanding, last_grant and err_unexpected.
  - In-flight controller reads are discarded; the controller is reset together with this block.

## Timing
- Reset values: req_ready 0, sram_addr_valid 0, sram_addr 0, sram_data_in 0, sram_write_mask 0, rd_valid 0, rd_data 0, outstanding 0, err_unexpected 0.
- Grant cycle t gives sram_addr_valid at t+1.
- Back-to-back throughput: 1 command per cycle while sram_ready=1.
- sram_data_out_valid at cycle t gives rd_valid/rd_data at t+1.
- req_ready depends combinationally on req_valid, req_write, rd_space, sram_ready and internal state. It never depends on itself.

## Test plan
- All 4 ports hold valid writes, sram_ready=1, round-robin -> grants 0,1,2,3,0,... one per cycle; sram_addr follows each port's address with 1-cycle latency.
- Same stimulus with FIXED_PRIORITY=1 -> port 0 granted every cycle; ports 1–3 starve until port 0 drops valid.
- Port 2 reads addr 0x00010 while sram_ready is low for 3 cycles -> command held stable with mask 0; data 0xDEADBEEF returned -> rd_valid=4'b0100, rd_data=0xDEADBEEF one cycle later.
- 8 reads are outstanding and port 1 requests a read while port 3 requests a write -> only the write is granted; after one return, port 1's read is granted on the following eligible cycle.
- rd_space[0]=0 with a port-0 read pending and a port-1 write pending -> port 1 granted; port 0 is granted after rd_space[0] rises.
- sram_data_out_valid with outstanding=0 -> no rd_valid, err_unexpected=1 and sticky; reset_n pulsed low mid-burst -> every output returns to its reset value immediately.
